// File: rtl/wb_bus_splitter_n.sv
// wb_bus_splitter_n
//   Splits one Wishbone classic master into NUM_SLAVES slave ports. The
//   slave regions are equal in size, contiguous and power-of-two sized,
//   and slave 0 starts at BASE_ADDR. All slave-side strobes and all
//   master-side responses are registered, so there is at most one
//   transfer in flight. An unmapped address returns a bus error. A slave
//   that stays silent for too long is cut off by a watchdog. A master
//   that drops cyc aborts the transfer cleanly.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock, asynchronous active-low reset
//   m_wb_cyc/stb/we/adr/dat/sel_i master request
//   m_wb_dat_o/ack_o/err_o       master response (one-cycle pulses)
//   s_wb_cyc_o/stb_o             one-hot per-slave cycle / strobe
//   s_wb_we/adr/dat/sel_o        broadcast latched request fields
//   s_wb_dat_i                   slave read data, slave i at [i*DW +: DW]
//   s_wb_ack_i/err_i             per-slave responses
//   timeout_o                    one-cycle pulse when the watchdog fires
module wb_bus_splitter_n #(
  parameter int              NUM_SLAVES = 4,
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter logic [AW-1:0]   BASE_ADDR  = 32'h3000_0000,
  parameter int              SPAN_LOG2  = 12,
  parameter int              TIMEOUT    = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic                     m_wb_cyc_i,
  input  logic                     m_wb_stb_i,
  input  logic                     m_wb_we_i,
  input  logic [AW-1:0]            m_wb_adr_i,
  input  logic [DW-1:0]            m_wb_dat_i,
  input  logic [DW/8-1:0]          m_wb_sel_i,
  output logic [DW-1:0]            m_wb_dat_o,
  output logic                     m_wb_ack_o,
  output logic                     m_wb_err_o,
  output logic [NUM_SLAVES-1:0]    s_wb_cyc_o,
  output logic [NUM_SLAVES-1:0]    s_wb_stb_o,
  output logic                     s_wb_we_o,
  output logic [AW-1:0]            s_wb_adr_o,
  output logic [DW-1:0]            s_wb_dat_o,
  output logic [DW/8-1:0]          s_wb_sel_o,
  input  logic [NUM_SLAVES*DW-1:0] s_wb_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_wb_ack_i,
  input  logic [NUM_SLAVES-1:0]    s_wb_err_i,
  output logic                     timeout_o
);

  localparam int            IW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int            SW      = DW / 8;
  localparam logic [15:0]   TMO_LIM = 16'(TIMEOUT);
  localparam logic [AW:0]   NS_EXT  = (AW + 1)'(NUM_SLAVES);
  localparam logic [AW:0]   BASE_EXT = {1'b0, BASE_ADDR};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [15:0]           wdog_q, wdog_d;
  logic [NUM_SLAVES-1:0] stb_q, stb_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic [DW-1:0]         wdat_q, wdat_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [DW-1:0]         rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;

  // Address decode, done one bit wider than the bus so that addresses
  // near the top of the space cannot wrap back into a valid region.
  logic [AW:0]           adr_ext, off_ext, blk_ext;
  logic                  hit;
  logic [IW-1:0]         dec_idx;
  logic [NUM_SLAVES-1:0] dec_onehot;

  always_comb begin
    adr_ext = {1'b0, m_wb_adr_i};
    off_ext = adr_ext - BASE_EXT;
    blk_ext = off_ext >> SPAN_LOG2;
    hit     = (adr_ext >= BASE_EXT) && (blk_ext < NS_EXT);
    dec_idx = blk_ext[IW-1:0];
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = (dec_idx == IW'(i));
    end
  end

  // Only the slave that owns the current transfer may answer it.
  logic          sel_ack, sel_err;
  logic [DW-1:0] sel_dat;

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IW'(i)) begin
        sel_ack = s_wb_ack_i[i];
        sel_err = s_wb_err_i[i];
        sel_dat = s_wb_dat_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wdog_d  = wdog_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i) begin
          we_d   = m_wb_we_i;
          adr_d  = m_wb_adr_i;
          wdat_d = m_wb_dat_i;
          sel_d  = m_wb_sel_i;
          if (hit) begin
            idx_d   = dec_idx;
            stb_d   = dec_onehot;
            wdog_d  = '0;
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // Abort beats any response arriving in the same cycle; a real
        // response beats the watchdog expiring in the same cycle.
        if (!m_wb_cyc_i) begin
          stb_d   = '0;
          state_d = S_IDLE;
        end else if (sel_err) begin
          err_d   = 1'b1;
          stb_d   = '0;
          state_d = S_RESP;
        end else if (sel_ack) begin
          ack_d   = 1'b1;
          rdat_d  = sel_dat;
          stb_d   = '0;
          state_d = S_RESP;
        end else if (wdog_q == TMO_LIM) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          stb_d   = '0;
          state_d = S_RESP;
        end else begin
          wdog_d  = wdog_q + 16'd1;
        end
      end
      S_RESP: begin
        // The response pulse is visible for exactly this one cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        stb_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wdog_q  <= '0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Each slave sees cyc and stb together, so one register drives both.
  assign s_wb_cyc_o = stb_q;
  assign s_wb_stb_o = stb_q;
  assign s_wb_we_o  = we_q;
  assign s_wb_adr_o = adr_q;
  assign s_wb_dat_o = wdat_q;
  assign s_wb_sel_o = sel_q;
  assign m_wb_dat_o = rdat_q;
  assign m_wb_ack_o = ack_q;
  assign m_wb_err_o = err_q;
  assign timeout_o  = tmo_q;

endmodule

// File: tb/tb_wb_bus_splitter_n.sv
module tb_wb_bus_splitter_n;

  localparam int          NS   = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [31:0]   adr_i = '0, dat_i = '0;
  logic [3:0]    sel_i = '0;
  logic [31:0]   m_dat_o;
  logic          m_ack_o, m_err_o, tmo_o;
  logic [3:0]    s_cyc_o, s_stb_o;
  logic          s_we_o;
  logic [31:0]   s_adr_o, s_dat_o;
  logic [3:0]    s_sel_o;
  logic [127:0]  sdat = '0;
  logic [3:0]    sack = '0, serr = '0;

  wb_bus_splitter_n #(
    .NUM_SLAVES(NS), .AW(32), .DW(32), .BASE_ADDR(BASE),
    .SPAN_LOG2(12), .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_wb_cyc_i(cyc_i), .m_wb_stb_i(stb_i), .m_wb_we_i(we_i),
    .m_wb_adr_i(adr_i), .m_wb_dat_i(dat_i), .m_wb_sel_i(sel_i),
    .m_wb_dat_o(m_dat_o), .m_wb_ack_o(m_ack_o), .m_wb_err_o(m_err_o),
    .s_wb_cyc_o(s_cyc_o), .s_wb_stb_o(s_stb_o), .s_wb_we_o(s_we_o),
    .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel_o),
    .s_wb_dat_i(sdat), .s_wb_ack_i(sack), .s_wb_err_i(serr),
    .timeout_o(tmo_o)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current cycle, filled in by the driver.
  logic [3:0]  e_stb = '0;
  logic        e_ack = 1'b0, e_err = 1'b0, e_tmo = 1'b0;
  logic [31:0] e_mdat = '0, e_sadr = '0, e_sdat = '0;
  logic [3:0]  e_sel = '0;
  logic        e_we = 1'b0;
  bit          chk_en = 1'b0;

  int n_cmp = 0, n_fail = 0;
  int cyc_cnt = 0;
  int ack_cnt = 0, err_cnt = 0, tmo_cnt = 0;
  int rise_cyc = 0, tmo_cyc = 0;
  logic [3:0] prev_stb = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_cyc", 64'(s_cyc_o), 64'(e_stb));
      chk("s_stb", 64'(s_stb_o), 64'(e_stb));
      chk("m_ack", 64'(m_ack_o), 64'(e_ack));
      chk("m_err", 64'(m_err_o), 64'(e_err));
      chk("timeout", 64'(tmo_o), 64'(e_tmo));
      chk("m_dat", 64'(m_dat_o), 64'(e_mdat));
      chk("s_adr", 64'(s_adr_o), 64'(e_sadr));
      chk("s_dat", 64'(s_dat_o), 64'(e_sdat));
      chk("s_sel", 64'(s_sel_o), 64'(e_sel));
      chk("s_we", 64'(s_we_o), 64'(e_we));
    end
    if (m_ack_o) ack_cnt++;
    if (m_err_o) err_cnt++;
    if (tmo_o) begin tmo_cnt++; tmo_cyc = cyc_cnt; end
    if (s_stb_o != 4'd0 && prev_stb == 4'd0) rise_cyc = cyc_cnt;
    prev_stb = s_stb_o;
  end

  task automatic noise(input logic [3:0] keep_quiet, input bit en);
    sdat = {$urandom(), $urandom(), $urandom(), $urandom()};
    sack = en ? (4'($urandom()) & ~keep_quiet) : 4'd0;
    serr = en ? (4'($urandom()) & ~keep_quiet) : 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc_i = 1'b0; stb_i = 1'b0;
      noise(4'd0, 1'b1);
      e_stb = '0; e_ack = 1'b0; e_err = 1'b0; e_tmo = 1'b0;
    end
  endtask

  // One master transfer. d = slave wait states (response in stb cycle d+1;
  // d > TMO means the slave never answers). rkind: 0 ack, 1 err, 2 both.
  // abort_at > 0: master drops cyc in that cycle (1 = first strobe cycle).
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                        input logic [3:0] sel, input int d, input int rkind,
                        input logic [31:0] rdat, input int abort_at, input bit nz);
    longint a, off;
    bit     hit;
    int     idx, r, kind, last, last_stb;
    logic [3:0] oh;
    a   = longint'(adr);
    off = a - longint'(BASE);
    hit = (a >= longint'(BASE)) && (off / 4096 < NS);
    idx = hit ? int'(off / 4096) : 0;
    oh  = hit ? 4'(1 << idx) : 4'd0;
    if (d <= TMO) begin r = 1 + d; kind = (rkind == 0) ? 0 : 1; end
    else begin r = 1 + TMO; kind = 2; end
    last     = !hit ? 1 : (abort_at > 0 ? abort_at : r + 1);
    last_stb = abort_at > 0 ? abort_at : r;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      cyc_i = !(abort_at > 0 && c >= abort_at);
      stb_i = cyc_i;
      adr_i = adr; we_i = we; dat_i = wdat; sel_i = sel;
      noise(oh, nz);
      if (hit && d <= TMO && c == 1 + d) begin
        sdat[idx*32 +: 32] = rdat;
        if (rkind != 1) sack[idx] = 1'b1;
        if (rkind != 0) serr[idx] = 1'b1;
      end
      e_stb = (hit && c >= 1 && c <= last_stb) ? oh : 4'd0;
      e_ack = hit && abort_at == 0 && kind == 0 && c == r + 1;
      e_err = (!hit && c == 1) || (hit && abort_at == 0 && kind != 0 && c == r + 1);
      e_tmo = hit && abort_at == 0 && kind == 2 && c == r + 1;
      if (e_ack) e_mdat = rdat;
      if (c == 1) begin e_sadr = adr; e_sdat = wdat; e_sel = sel; e_we = we; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timed out");
  end

  initial begin
    int a0, e0, t0;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", 64'(s_stb_o), 64'd0);
    chk("rst_ack_err_tmo", 64'({m_ack_o, m_err_o, tmo_o}), 64'd0);
    chk("rst_mdat", 64'(m_dat_o), 64'd0);
    chk("rst_sadr", 64'(s_adr_o), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Read slave 2 with one wait state.
    a0 = ack_cnt;
    do_txn(32'h3000_2004, 1'b0, 32'h0, 4'hF, 1, 0, 32'hDEAD_BEEF, 0, 1'b1);
    idle(1);
    chk("rd_ack_count", 64'(ack_cnt - a0), 64'd1);
    chk("rd_dat_lit", 64'(m_dat_o), 64'hDEAD_BEEF);
    chk("rd_adr_lit", 64'(s_adr_o), 64'h3000_2004);

    // Write slave 0, zero-wait.
    a0 = ack_cnt;
    do_txn(32'h3000_0010, 1'b1, 32'h1234_5678, 4'b0011, 0, 0, 32'h5555_AAAA, 0, 1'b1);
    idle(1);
    chk("wr_ack_count", 64'(ack_cnt - a0), 64'd1);
    chk("wr_sdat_lit", 64'(s_dat_o), 64'h1234_5678);
    chk("wr_sel_we_lit", 64'({s_sel_o, s_we_o}), 64'b00111);

    // Unmapped above and below.
    e0 = err_cnt;
    do_txn(32'h3000_4000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 0, 1'b1);
    do_txn(32'h2FFF_FFFC, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0, 0, 1'b1);
    idle(1);
    chk("miss_err_count", 64'(err_cnt - e0), 64'd2);

    // Silent slave 1 -> watchdog.
    t0 = tmo_cnt;
    do_txn(32'h3000_1000, 1'b0, 32'h0, 4'hF, 1000, 0, 32'h0, 0, 1'b1);
    idle(1);
    chk("tmo_count", 64'(tmo_cnt - t0), 64'd1);
    chk("tmo_latency", 64'(tmo_cyc - rise_cyc), 64'd9);
    a0 = ack_cnt;
    do_txn(32'h3000_3020, 1'b0, 32'h0, 4'hF, 2, 0, 32'hCAFE_0003, 0, 1'b1);
    idle(1);
    chk("after_tmo_ack", 64'(ack_cnt - a0), 64'd1);

    // Ack and err together from slave 3: err only, data unchanged.
    a0 = ack_cnt; e0 = err_cnt;
    do_txn(32'h3000_3000, 1'b0, 32'h0, 4'hF, 1, 2, 32'h0BAD_0BAD, 0, 1'b1);
    idle(1);
    chk("both_err", 64'(err_cnt - e0), 64'd1);
    chk("both_no_ack", 64'(ack_cnt - a0), 64'd0);
    chk("both_dat_kept", 64'(m_dat_o), 64'hCAFE_0003);

    // Slave 0 acks exactly on the watchdog limit: ack wins.
    a0 = ack_cnt; t0 = tmo_cnt;
    do_txn(32'h3000_0000, 1'b0, 32'h0, 4'hF, TMO, 0, 32'h7777_0000, 0, 1'b1);
    idle(1);
    chk("edge_ack", 64'(ack_cnt - a0), 64'd1);
    chk("edge_no_tmo", 64'(tmo_cnt - t0), 64'd0);

    // Master abort three cycles into the wait.
    a0 = ack_cnt; e0 = err_cnt;
    do_txn(32'h3000_2000, 1'b0, 32'h0, 4'hF, 1000, 0, 32'h0, 4, 1'b1);
    idle(2);
    chk("abort_no_resp", 64'((ack_cnt - a0) + (err_cnt - e0)), 64'd0);
    chk("abort_stb_clear", 64'(s_stb_o), 64'd0);

    // Asynchronous reset in the middle of a wait.
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h3000_1008;
    dat_i = 32'hA5A5_0001; sel_i = 4'hF; sack = '0; serr = '0;
    e_stb = '0; e_ack = 1'b0; e_err = 1'b0; e_tmo = 1'b0;
    @(posedge clk); #1;
    e_stb = 4'b0010; e_sadr = adr_i; e_sdat = dat_i; e_sel = sel_i; e_we = 1'b1;
    @(posedge clk); #1;
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_stb", 64'(s_stb_o), 64'd0);
    chk("arst_cyc", 64'(s_cyc_o), 64'd0);
    chk("arst_resp", 64'({m_ack_o, m_err_o, tmo_o}), 64'd0);
    chk("arst_mdat", 64'(m_dat_o), 64'd0);
    cyc_i = 1'b0; stb_i = 1'b0;
    e_stb = '0; e_mdat = '0; e_sadr = '0; e_sdat = '0; e_sel = '0; e_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);
    a0 = ack_cnt;
    do_txn(32'h3000_1008, 1'b0, 32'h0, 4'hF, 0, 0, 32'h1111_2222, 0, 1'b1);
    idle(1);
    chk("post_rst_ack", 64'(ack_cnt - a0), 64'd1);

    // Randomised traffic.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] adr;
      int d, rk, ab, sel_case;
      sel_case = $urandom_range(0, 9);
      if (sel_case <= 6)
        adr = BASE + 32'($urandom_range(0, NS - 1)) * 32'h1000 + 32'($urandom_range(0, 1023)) * 4;
      else if (sel_case == 7)
        adr = 32'h3000_4000 + 32'($urandom_range(0, 4095)) * 4;
      else if (sel_case == 8)
        adr = BASE - 32'($urandom_range(1, 1000)) * 4;
      else
        adr = $urandom() & 32'hFFFF_FFFC;
      d  = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 4);
      rk = $urandom_range(0, 2);
      ab = 0;
      if (d >= 1 && $urandom_range(0, 9) == 0)
        ab = $urandom_range(1, (d < TMO) ? d : TMO);
      do_txn(adr, 1'($urandom()), $urandom(), 4'($urandom()), d, rk, $urandom(), ab,
             1'($urandom()));
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bus_splitter_n.md
Name: wb_bus_splitter_n

Overview:
- Parametrised successor to the fixed four-port Wishbone splitter between the Caravel user Wishbone slave port and the user-area peripherals (PWM timers, etc.).
- Decodes master cycles into NUM_SLAVES equal, contiguous, power-of-two regions above BASE_ADDR.
- Registers all slave-side strobes and master-side responses.
- Adds a bus-error response for unmapped addresses, a per-transaction watchdog timeout, and clean abort when the master drops cyc.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- BASE_ADDR, 32'h3000_0000, start of slave 0 region.
- SPAN_LOG2, 12, log2 of each region size in bytes (4 KB default).
- TIMEOUT, 255, maximum wait cycles for a slave response (1..65535).

Ports:
- wb_clk_i  in  1  bus clock; sole clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- m_wb_cyc_i / m_wb_stb_i / m_wb_we_i  in  1 each  master cycle / strobe / write enable.
- m_wb_adr_i  in  AW  master byte address.
- m_wb_dat_i  in  DW  master write data.
- m_wb_sel_i  in  DW/8  master byte selects.
- m_wb_dat_o  out  DW  read data, registered, valid with m_wb_ack_o.
- m_wb_ack_o  out  1  one-cycle ack pulse.
- m_wb_err_o  out  1  one-cycle error pulse.
- s_wb_cyc_o, s_wb_stb_o  out  NUM_SLAVES  one-hot per-slave cycle / strobe.
- s_wb_we_o  out  1  broadcast write enable.
- s_wb_adr_o  out  AW  broadcast latched full address.
- s_wb_dat_o  out  DW  broadcast latched write data.
- s_wb_sel_o  out  DW/8  broadcast latched byte selects.
- s_wb_dat_i  in  NUM_SLAVES*DW  flattened slave read data; slave i at bits [i*DW +: DW].
- s_wb_ack_i, s_wb_err_i  in  NUM_SLAVES  per-slave ack / err.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (wb_rst_ni low, asynchronous): all outputs 0, FSM in IDLE, watchdog counter 0, slave index 0.
- Decode: off = m_wb_adr_i - BASE_ADDR; idx = off >> SPAN_LOG2.
  - Hit when m_wb_adr_i >= BASE_ADDR and idx < NUM_SLAVES.
  - Compare in AW+1 bits so there is no wrap-around at the top of the address space.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on m_wb_cyc_i & m_wb_stb_i, latch adr, dat, sel, we and idx.
  - Hit: go to WAIT. s_wb_cyc_o[idx] and s_wb_stb_o[idx] rise on the next edge.
  - Miss: go to RESP with m_wb_err_o=1 on the next cycle. No slave is strobed.
- WAIT: selected strobes held high; watchdog increments each cycle, starting at 0.
  - s_wb_ack_i[idx]: capture s_wb_dat_i slice into m_wb_dat_o, pulse m_wb_ack_o next cycle, drop strobes, go to RESP.
  - s_wb_err_i[idx]: same sequence with m_wb_err_o instead of ack; dat_o unchanged.
  - Ack and err together: err wins.
  - Watchdog == TIMEOUT with no response: pulse m_wb_err_o and timeout_o, drop strobes, go to RESP.
  - Response in the same cycle the watchdog reaches TIMEOUT: the response wins, no timeout_o.
  - ack/err from non-selected slaves is ignored at all times.
  - m_wb_cyc_i low in WAIT (abort): drop strobes next edge, return to IDLE, no ack/err/timeout.
- RESP: response pulse is exactly one cycle; return to IDLE unconditionally.
  - A master still holding stb is re-decoded as a new transfer. Masters deassert stb on ack, per Wishbone classic.
- Latency, hit: request seen at cycle 0; slave strobe at 1; slave ack at cycle k gives m_wb_ack_o at k+1. Minimum 2 cycles with a zero-wait slave (ack combinational with stb).
- Latency, miss: m_wb_err_o at cycle 1.
- Throughput: at most one outstanding transfer; no pipelining.
- m_wb_dat_o holds its last captured value between reads.
- Asynchronous reset mid-transfer: strobes and responses clear immediately; the transfer is lost.

Test Plan:
- Read 0x3000_2004, slave 2 acks one cycle after stb with 0xDEAD_BEEF -> only s_wb_stb_o[2] high; m_wb_ack_o one cycle with m_wb_dat_o=0xDEAD_BEEF; s_wb_adr_o=0x3000_2004.
- Write 0x3000_0010, data 0x1234_5678, sel 4'b0011, slave 0 ack -> s_wb_dat_o/s_wb_sel_o/s_wb_we_o latched correctly; single ack; no other slave strobed.
- Access 0x3000_4000 (idx 4, NUM_SLAVES=4), then 0x2FFF_FFFC -> m_wb_err_o at cycle 1 for each; s_wb_stb_o stays 0.
- Slave 1 never responds, TIMEOUT=8 -> m_wb_err_o and timeout_o pulse together 9 cycles after the strobe rises; strobe drops; a next access to slave 3 succeeds.
- Slave 3 asserts ack and err together; separately, slave 0 acks on the watchdog==TIMEOUT cycle -> first gives err only; second gives ack only, no timeout_o.
- Master drops cyc 3 cycles into WAIT; separately, wb_rst_ni pulses low mid-WAIT -> strobes clear (abort next edge, reset immediately); no ack/err; bus returns to IDLE and the next transfer works.
